// File: rtl/rtc_pkg.sv
// Shared time-of-day field widths, limits and the packed time type for the RTC.
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int TIME_W = HOUR_W + MIN_W + SEC_W;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } rtc_time_t;

    function automatic logic time_in_range(input rtc_time_t t);
        return (t.sec <= SEC_MAX) && (t.min <= MIN_MAX) && (t.hour <= HOUR_MAX);
    endfunction

endpackage

// File: rtl/rtc_alarm_cmp.sv
// One alarm channel: compares the upcoming time with the alarm setting and
// emits a registered single-cycle pulse when the match first appears.
module rtc_alarm_cmp
    import rtc_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  rtc_time_t time_d_i,
    input  logic      en_i,
    input  rtc_time_t alarm_i,
    output logic      hit_o
);

    logic match_d;
    logic match_q;
    logic hit_q;

    // Matching against the next-state time lets the pulse appear in the same
    // cycle the matching time becomes visible on the outputs.
    always_comb begin
        match_d = en_i && time_in_range(alarm_i) && (time_d_i == alarm_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            match_q <= match_d;
            hit_q   <= match_d && !match_q;
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/rtc_core.sv
// Real-time clock core: prescaled seconds counter with 24h time, load
// handshake, optional 12h display format and per-channel alarms.
module rtc_core
    import rtc_pkg::*;
#(
    parameter int NUM_ALARMS = 2,
    parameter int HOUR12     = 0,
    parameter int TICK_DIV   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick_en,
    input  logic                         run,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [SEC_W-1:0]             load_sec,
    input  logic [MIN_W-1:0]             load_min,
    input  logic [HOUR_W-1:0]            load_hour,
    output logic                         load_err,
    output logic [SEC_W-1:0]             seconds,
    output logic [MIN_W-1:0]             minutes,
    output logic [HOUR_W-1:0]            hours,
    output logic                         pm,
    output logic                         day_wrap,
    input  logic [NUM_ALARMS-1:0]        alarm_en,
    input  logic [NUM_ALARMS*TIME_W-1:0] alarm_time,
    output logic [NUM_ALARMS-1:0]        alarm_hit
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    rtc_time_t         time_q, time_d;
    rtc_time_t         load_time;
    logic [PW-1:0]     pre_q, pre_d;
    logic              load_ready_q, load_ready_d;
    logic              load_err_q, load_err_d;
    logic              day_wrap_q, day_wrap_d;
    logic [HOUR_W-1:0] hours_q, hours_d;
    logic              pm_q, pm_d;
    logic              load_fire, load_ok, count_en, sec_step;

    always_comb begin
        load_time = {load_hour, load_min, load_sec};
        load_fire = load_valid && load_ready_q;
        load_ok   = load_fire && time_in_range(load_time);
        count_en  = run && tick_en;
        sec_step  = count_en && (pre_q == PRE_LAST);

        pre_d = pre_q;
        if (load_ok) begin
            pre_d = '0;
        end else if (count_en) begin
            pre_d = sec_step ? '0 : pre_q + 1'b1;
        end

        // An accepted load takes priority over a coincident second step.
        time_d     = time_q;
        day_wrap_d = 1'b0;
        if (load_ok) begin
            time_d = load_time;
        end else if (sec_step) begin
            if (time_q.sec == SEC_MAX) begin
                time_d.sec = '0;
                if (time_q.min == MIN_MAX) begin
                    time_d.min = '0;
                    if (time_q.hour == HOUR_MAX) begin
                        time_d.hour = '0;
                        day_wrap_d  = 1'b1;
                    end else begin
                        time_d.hour = time_q.hour + 1'b1;
                    end
                end else begin
                    time_d.min = time_q.min + 1'b1;
                end
            end else begin
                time_d.sec = time_q.sec + 1'b1;
            end
        end

        load_ready_d = !load_fire;
        load_err_d   = load_fire && !load_ok;

        hours_d = time_d.hour;
        pm_d    = 1'b0;
        if (HOUR12 != 0) begin
            pm_d = (time_d.hour >= 5'd12);
            if (time_d.hour == 5'd0) begin
                hours_d = 5'd12;
            end else if (time_d.hour > 5'd12) begin
                hours_d = time_d.hour - 5'd12;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q       <= '0;
            pre_q        <= '0;
            load_ready_q <= 1'b1;
            load_err_q   <= 1'b0;
            day_wrap_q   <= 1'b0;
            hours_q      <= (HOUR12 != 0) ? 5'd12 : 5'd0;
            pm_q         <= 1'b0;
        end else begin
            time_q       <= time_d;
            pre_q        <= pre_d;
            load_ready_q <= load_ready_d;
            load_err_q   <= load_err_d;
            day_wrap_q   <= day_wrap_d;
            hours_q      <= hours_d;
            pm_q         <= pm_d;
        end
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
        rtc_alarm_cmp u_cmp (
            .clk      (clk),
            .reset    (reset),
            .time_d_i (time_d),
            .en_i     (alarm_en[gi]),
            .alarm_i  (alarm_time[gi*TIME_W +: TIME_W]),
            .hit_o    (alarm_hit[gi])
        );
    end

    assign load_ready = load_ready_q;
    assign load_err   = load_err_q;
    assign seconds    = time_q.sec;
    assign minutes    = time_q.min;
    assign hours      = hours_q;
    assign pm         = pm_q;
    assign day_wrap   = day_wrap_q;

endmodule

// File: tb/tb_rtc_core.sv
// Directed bench for rtc_core: three configurations share one stimulus and are
// checked every cycle against a seconds-of-day model plus literal spot checks.
module tb_rtc_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_en, run, load_valid;
    logic [5:0]  load_sec, load_min;
    logic [4:0]  load_hour;
    logic [1:0]  alarm_en;
    logic [33:0] alarm_time;

    logic       rdy_o[3];
    logic       err_o[3];
    logic [5:0] sec_o[3];
    logic [5:0] min_o[3];
    logic [4:0] hr_o[3];
    logic       pm_o[3];
    logic       wrap_o[3];
    logic [1:0] hit_o[3];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults; 1: TICK_DIV=4; 2: HOUR12=1.
    rtc_core #(.NUM_ALARMS(2), .HOUR12(0), .TICK_DIV(1)) u_dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .run(run),
        .load_valid(load_valid), .load_ready(rdy_o[0]),
        .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
        .load_err(err_o[0]), .seconds(sec_o[0]), .minutes(min_o[0]),
        .hours(hr_o[0]), .pm(pm_o[0]), .day_wrap(wrap_o[0]),
        .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_hit(hit_o[0]));

    rtc_core #(.NUM_ALARMS(2), .HOUR12(0), .TICK_DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .run(run),
        .load_valid(load_valid), .load_ready(rdy_o[1]),
        .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
        .load_err(err_o[1]), .seconds(sec_o[1]), .minutes(min_o[1]),
        .hours(hr_o[1]), .pm(pm_o[1]), .day_wrap(wrap_o[1]),
        .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_hit(hit_o[1]));

    rtc_core #(.NUM_ALARMS(2), .HOUR12(1), .TICK_DIV(1)) u_h12 (
        .clk(clk), .reset(reset), .tick_en(tick_en), .run(run),
        .load_valid(load_valid), .load_ready(rdy_o[2]),
        .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
        .load_err(err_o[2]), .seconds(sec_o[2]), .minutes(min_o[2]),
        .hours(hr_o[2]), .pm(pm_o[2]), .day_wrap(wrap_o[2]),
        .alarm_en(alarm_en), .alarm_time(alarm_time), .alarm_hit(hit_o[2]));

    // Model state: time as seconds since midnight.
    int m_tod[3];
    int m_pre[3];
    bit m_rdy[3];
    bit m_err[3];
    bit m_wrap[3];
    bit m_prev[3][2];
    bit m_hit[3][2];
    bit model_valid = 1'b0;
    int m_div[3] = '{1, 4, 1};
    bit m_h12[3] = '{1'b0, 1'b0, 1'b1};

    task automatic model_step();
        bit fire, ok, step, now;
        int ah, am, as_;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_tod[k] = 0; m_pre[k] = 0; m_rdy[k] = 1'b1;
                m_err[k] = 1'b0; m_wrap[k] = 1'b0;
                for (int a = 0; a < 2; a++) begin
                    m_prev[k][a] = 1'b0; m_hit[k][a] = 1'b0;
                end
            end else begin
                fire = load_valid && m_rdy[k];
                ok   = fire && load_sec < 60 && load_min < 60 && load_hour < 24;
                step = run && tick_en && (m_pre[k] == m_div[k] - 1);
                if (ok) m_pre[k] = 0;
                else if (run && tick_en) m_pre[k] = step ? 0 : m_pre[k] + 1;
                m_wrap[k] = 1'b0;
                if (ok) begin
                    m_tod[k] = int'(load_hour) * 3600 + int'(load_min) * 60 + int'(load_sec);
                end else if (step) begin
                    m_wrap[k] = (m_tod[k] == 86399);
                    m_tod[k]  = (m_tod[k] + 1) % 86400;
                end
                m_err[k] = fire && !ok;
                m_rdy[k] = !fire;
                for (int a = 0; a < 2; a++) begin
                    ah  = int'(alarm_time[a*17+12 +: 5]);
                    am  = int'(alarm_time[a*17+6 +: 6]);
                    as_ = int'(alarm_time[a*17 +: 6]);
                    now = alarm_en[a] && ah < 24 && am < 60 && as_ < 60 &&
                          (m_tod[k] == ah * 3600 + am * 60 + as_);
                    m_hit[k][a]  = now && !m_prev[k][a];
                    m_prev[k][a] = now;
                end
            end
        end
        if (reset) model_valid = 1'b1;
    endtask

    // Outputs are sampled on the falling edge; inputs only change just after rising edges.
    initial begin
        int h, eh;
        bit epm;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                for (int k = 0; k < 3; k++) begin
                    h   = m_tod[k] / 3600;
                    eh  = h;
                    epm = 1'b0;
                    if (m_h12[k]) begin
                        epm = (h >= 12);
                        eh  = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
                    end
                    checks++;
                    if (int'(sec_o[k]) != m_tod[k] % 60 || int'(min_o[k]) != (m_tod[k] / 60) % 60 ||
                        int'(hr_o[k]) != eh || pm_o[k] !== epm || wrap_o[k] !== m_wrap[k] ||
                        err_o[k] !== m_err[k] || rdy_o[k] !== m_rdy[k] ||
                        hit_o[k] !== {m_hit[k][1], m_hit[k][0]}) begin
                        $display("FAIL model[%0d] t=%0t got h%0d m%0d s%0d pm%0b wrap%0b err%0b rdy%0b hit%b exp h%0d m%0d s%0d pm%0b wrap%0b err%0b rdy%0b hit%b",
                                 k, $time, hr_o[k], min_o[k], sec_o[k], pm_o[k], wrap_o[k], err_o[k],
                                 rdy_o[k], hit_o[k], eh, (m_tod[k] / 60) % 60, m_tod[k] % 60, epm,
                                 m_wrap[k], m_err[k], m_rdy[k], {m_hit[k][1], m_hit[k][0]});
                    end else begin
                        passes++;
                    end
                end
            end
            model_step();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) $display("FAIL %s got %0d expected %0d", name, act, exp);
        else passes++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_hour  = 5'(h);
        load_min   = 6'(m);
        load_sec   = 6'(s);
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        $display("load %0d:%0d:%0d -> dut %0d:%0d:%0d err=%0b", h, m, s,
                 hr_o[0], min_o[0], sec_o[0], err_o[0]);
    endtask

    initial begin
        int hits0, hits1;
        reset = 1'b1; tick_en = 1'b0; run = 1'b0; load_valid = 1'b0;
        load_sec = '0; load_min = '0; load_hour = '0;
        alarm_en = '0; alarm_time = '0;
        repeat (3) cyc();
        chk("rst_sec", int'(sec_o[0]), 0);
        chk("rst_h12_hours", int'(hr_o[2]), 12);
        chk("rst_h12_pm", int'(pm_o[2]), 0);
        chk("rst_ready", int'(rdy_o[0]), 1);
        reset = 1'b0;
        cyc();

        // Day wrap from 23:59:58 with two seconds.
        do_load(23, 59, 58);
        chk("load_2359_hour", int'(hr_o[0]), 23);
        chk("load_2359_sec", int'(sec_o[0]), 58);
        chk("ready_low_after_load", int'(rdy_o[0]), 0);
        run = 1'b1; tick_en = 1'b1;
        cyc();
        chk("tick1_sec", int'(sec_o[0]), 59);
        chk("tick1_wrap", int'(wrap_o[0]), 0);
        cyc();
        chk("wrap_hour", int'(hr_o[0]), 0);
        chk("wrap_sec", int'(sec_o[0]), 0);
        chk("wrap_pulse", int'(wrap_o[0]), 1);
        tick_en = 1'b0;
        cyc();
        chk("wrap_pulse_end", int'(wrap_o[0]), 0);

        // Prescaler: 8 ticks at TICK_DIV=4 give 2 seconds; run=0 freezes.
        do_load(0, 0, 0);
        cyc();
        tick_en = 1'b1;
        repeat (8) cyc();
        tick_en = 1'b0;
        chk("div4_sec", int'(sec_o[1]), 2);
        chk("div1_sec", int'(sec_o[0]), 8);
        run = 1'b0; tick_en = 1'b1;
        repeat (5) cyc();
        tick_en = 1'b0;
        chk("div4_hold", int'(sec_o[1]), 2);
        chk("div1_hold", int'(sec_o[0]), 8);

        // Out-of-range load.
        do_load(12, 60, 0);
        chk("bad_load_err", int'(err_o[0]), 1);
        chk("bad_load_hour", int'(hr_o[0]), 0);
        chk("bad_load_sec", int'(sec_o[0]), 8);
        chk("bad_load_ready", int'(rdy_o[0]), 0);
        cyc();
        chk("bad_load_err_end", int'(err_o[0]), 0);
        chk("bad_load_ready_back", int'(rdy_o[0]), 1);

        // Load wins over a coincident second step.
        run = 1'b1; tick_en = 1'b1;
        do_load(10, 0, 0);
        tick_en = 1'b0; run = 1'b0;
        chk("load_vs_step_hour", int'(hr_o[0]), 10);
        chk("load_vs_step_sec", int'(sec_o[0]), 0);
        cyc();

        // 12-hour display.
        do_load(0, 0, 0);
        chk("h12_midnight_hours", int'(hr_o[2]), 12);
        chk("h12_midnight_pm", int'(pm_o[2]), 0);
        cyc();
        do_load(13, 5, 0);
        chk("h12_1305_hours", int'(hr_o[2]), 1);
        chk("h12_1305_pm", int'(pm_o[2]), 1);
        chk("h24_1305_hours", int'(hr_o[0]), 13);
        cyc();

        // Alarms at 00:00:05, channel 0 enabled, channel 1 disabled.
        alarm_time = {5'd0, 6'd0, 6'd5, 5'd0, 6'd0, 6'd5};
        alarm_en   = 2'b01;
        do_load(0, 0, 0);
        cyc();
        hits0 = 0; hits1 = 0;
        run = 1'b1; tick_en = 1'b1;
        repeat (5) begin
            cyc();
            hits0 += int'(hit_o[0][0]);
            hits1 += int'(hit_o[0][1]);
        end
        chk("alarm_sec", int'(sec_o[0]), 5);
        chk("alarm_hit_now", int'(hit_o[0]), 1);
        run = 1'b0;
        repeat (4) begin
            cyc();
            hits0 += int'(hit_o[0][0]);
            hits1 += int'(hit_o[0][1]);
        end
        tick_en = 1'b0;
        chk("alarm0_count", hits0, 1);
        chk("alarm1_count", hits1, 0);

        repeat (2) cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rtc_core.md
RTC_CORE -- requirements
Module: rtc_core

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 2, number of independent alarm channels (1..8).
REQ-002 SHALL have parameter HOUR12, default 0, 0 = hours output 0..23, 1 = hours output 1..12 plus pm flag.
REQ-003 SHALL have parameter TICK_DIV, default 1, number of tick_en strobes per counted second (>=1).
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 tick_en  in  1  one-cycle timebase strobe.
REQ-007 run  in  1  1 = count; 0 = hold time, tick_en ignored.
REQ-008 load_valid  in  1  request to load time.
REQ-009 load_ready  out  1  load handshake ready.
REQ-010 load_sec / load_min  in  6 each  load values, binary.
REQ-011 load_hour  in  5  load value, always 24-hour binary 0..23.
REQ-012 load_err  out  1  one-cycle pulse, load rejected.
REQ-013 seconds / minutes  out  6 each  current time, binary.
REQ-014 hours  out  5  current hour, format per HOUR12.
REQ-015 pm  out  1  1 when internal hour >= 12; 0 when HOUR12 = 0.
REQ-016 day_wrap  out  1  one-cycle pulse on 23:59:59 -> 00:00:00.
REQ-017 alarm_en  in  NUM_ALARMS  per-channel enable.
REQ-018 alarm_time  in  NUM_ALARMS*17  per channel {hour[4:0], min[5:0], sec[5:0]}, 24-hour binary, channel 0 in LSBs.
REQ-019 alarm_hit  out  NUM_ALARMS  per-channel one-cycle match pulse.

Function
REQ-020 Internal time SHALL be held as 24-hour binary sec 0..59, min 0..59, hour 0..23.
REQ-021 A prescaler SHALL count tick_en strobes while run = 1 and produce a one-cycle sec_step when it reaches TICK_DIV-1, then return to 0; with TICK_DIV = 1, every tick_en is a sec_step.
REQ-022 On sec_step, time SHALL advance by one second in the following cycle: sec 59 -> 0 with a min carry; min 59 -> 0 with an hour carry; hour 23 -> 0 asserting day_wrap for one cycle.
REQ-023 run = 0 SHALL freeze the time and the prescaler; the prescaler value SHALL be retained.
REQ-024 load_ready SHALL be 1 in every cycle except the cycle immediately after an accepted or rejected load (one-cycle recovery).
REQ-025 A load SHALL be accepted when load_valid && load_ready and sec <= 59, min <= 59, hour <= 23; the new time SHALL be visible on the outputs in the next cycle and the prescaler SHALL clear to 0.
REQ-026 If any load field is out of range, time SHALL be unchanged and load_err SHALL pulse for one cycle in the next cycle.
REQ-027 When a load and a sec_step occur in the same cycle, the load SHALL win and the sec_step SHALL be discarded.
REQ-028 HOUR12 = 1 mapping: internal 0 -> 12 am; 1..11 -> same value, am; 12 -> 12 pm; 13..23 -> value minus 12, pm.
REQ-029 alarm_hit[i] SHALL pulse for one cycle in the cycle the registered time first equals alarm_time[i] while alarm_en[i] = 1, whether that time was reached by counting or by loading; it SHALL NOT re-pulse while the time is held.
REQ-030 An alarm_time field that is out of range SHALL never match.
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-032 On reset, time SHALL be 00:00:00 with the prescaler at 0, hours output 0 (12 when HOUR12 = 1), pm 0, day_wrap 0, load_err 0, alarm_hit all 0, and load_ready 1.
REQ-033 Reset SHALL override a load or sec_step in the same cycle; a load pending at reset SHALL be dropped.

Structure
REQ-034 Package rtc_pkg SHALL hold the limit constants (SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23), the field widths, and the packed time typedef {hour, min, sec}.
REQ-035 Per-channel compare-and-edge-detect logic SHALL be a single sub-module rtc_alarm_cmp, instantiated NUM_ALARMS times with a generate loop.

Verification
REQ-036 Load 23:59:58, TICK_DIV = 1, two tick_en -> 23:59:59, then 00:00:00 with a day_wrap pulse in that cycle.
REQ-037 TICK_DIV = 4, run = 1, 8 tick_en -> seconds advances exactly 2; run = 0 with 5 tick_en -> no change.
REQ-038 Load of 12:60:00 -> load_err pulses, time unchanged; next cycle load_ready = 0, following cycle 1.
REQ-039 Load 10:00:00 asserted in the same cycle as a sec_step -> output 10:00:00, not 10:00:01.
REQ-040 HOUR12 = 1: load 00:00:00 -> hours 12, pm 0; load 13:05:00 -> hours 1, pm 1.
REQ-041 Alarm 0 at 00:00:05 enabled, alarm 1 at the same time disabled -> only alarm_hit[0] pulses once at 00:00:05; run = 0 held at that time -> no repeat pulse.
